conv2d_window_sequencer: RTL and testbench

CONV2D_WINDOW_SEQUENCER -- requirements
Module: conv2d_window_sequencer

---
 rtl/conv2d_window_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_conv2d_window_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_window_sequencer
// Purpose  : Walks every (oh, ow, ci, kh, kw) point of a 2-D convolution and
//            offers one MAC operation per point over a valid/ready handshake,
//            with input/weight/output addresses and padding detection.
// Revision : 1.0 - initial release
// ============================================================================
module conv2d_window_sequencer #(
    parameter int IN_H     = 8,
    parameter int IN_W     = 12,
    parameter int CIN      = 3,
    parameter int KH       = 3,
    parameter int KW       = 5,
    parameter int STRIDE_H = 1,
    parameter int STRIDE_W = 2,
    parameter int PAD_H    = 1,
    parameter int PAD_W    = 2,
    parameter int DIL_H    = 1,
    parameter int DIL_W    = 1,
    parameter int AW       = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [AW-1:0] op_in_addr,
    output logic [AW-1:0] op_w_addr,
    output logic [AW-1:0] op_out_addr,
    output logic          op_pad,
    output logic          op_first,
    output logic          op_last
);

    // Output feature-map geometry
    localparam int OH = (IN_H + 2 * PAD_H - DIL_H * (KH - 1) - 1) / STRIDE_H + 1;
    localparam int OW = (IN_W + 2 * PAD_W - DIL_W * (KW - 1) - 1) / STRIDE_W + 1;

    // Loop counter widths (at least one bit even for a degenerate extent)
    localparam int c_OH_BW = (OH  > 1) ? $clog2(OH)  : 1;
    localparam int c_OW_BW = (OW  > 1) ? $clog2(OW)  : 1;
    localparam int c_CI_BW = (CIN > 1) ? $clog2(CIN) : 1;
    localparam int c_KH_BW = (KH  > 1) ? $clog2(KH)  : 1;
    localparam int c_KW_BW = (KW  > 1) ? $clog2(KW)  : 1;

    localparam logic [c_OH_BW-1:0] c_OH_LAST = c_OH_BW'(OH - 1);
    localparam logic [c_OW_BW-1:0] c_OW_LAST = c_OW_BW'(OW - 1);
    localparam logic [c_CI_BW-1:0] c_CI_LAST = c_CI_BW'(CIN - 1);
    localparam logic [c_KH_BW-1:0] c_KH_LAST = c_KH_BW'(KH - 1);
    localparam logic [c_KW_BW-1:0] c_KW_LAST = c_KW_BW'(KW - 1);

    // Signed coordinate arithmetic, two bits wider than an address so that
    // negative (top/left padding) and overflowing coordinates are exact.
    localparam int c_EW = AW + 2;
    typedef logic signed [c_EW-1:0] ext_t;

    localparam ext_t c_E_STRIDE_H = ext_t'(STRIDE_H);
    localparam ext_t c_E_STRIDE_W = ext_t'(STRIDE_W);
    localparam ext_t c_E_PAD_H    = ext_t'(PAD_H);
    localparam ext_t c_E_PAD_W    = ext_t'(PAD_W);
    localparam ext_t c_E_DIL_H    = ext_t'(DIL_H);
    localparam ext_t c_E_DIL_W    = ext_t'(DIL_W);
    localparam ext_t c_E_IN_H     = ext_t'(IN_H);
    localparam ext_t c_E_IN_W     = ext_t'(IN_W);

    // Address strides
    localparam logic [AW-1:0] c_A_PLANE = AW'(IN_H * IN_W);
    localparam logic [AW-1:0] c_A_IN_W  = AW'(IN_W);
    localparam logic [AW-1:0] c_A_KHKW  = AW'(KH * KW);
    localparam logic [AW-1:0] c_A_KW    = AW'(KW);
    localparam logic [AW-1:0] c_A_OW    = AW'(OW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [c_OH_BW-1:0] r_oh;
    logic [c_OW_BW-1:0] r_ow;
    logic [c_CI_BW-1:0] r_ci;
    logic [c_KH_BW-1:0] r_kh;
    logic [c_KW_BW-1:0] r_kw;

    logic w_xfer;
    logic w_kw_end, w_kh_end, w_ci_end, w_ow_end, w_oh_end;
    logic w_pix_first, w_pix_end, w_pass_end;
    ext_t w_ih, w_iw;
    logic w_pad;

    assign w_xfer      = (r_state == S_RUN) && op_ready;
    assign w_kw_end    = (r_kw == c_KW_LAST);
    assign w_kh_end    = (r_kh == c_KH_LAST);
    assign w_ci_end    = (r_ci == c_CI_LAST);
    assign w_ow_end    = (r_ow == c_OW_LAST);
    assign w_oh_end    = (r_oh == c_OH_LAST);
    assign w_pix_first = (r_ci == '0) && (r_kh == '0) && (r_kw == '0);
    assign w_pix_end   = w_ci_end && w_kh_end && w_kw_end;
    assign w_pass_end  = w_pix_end && w_ow_end && w_oh_end;

    // Input-tensor coordinates of the current tap and padding detection
    assign w_ih  = ext_t'(r_oh) * c_E_STRIDE_H - c_E_PAD_H + ext_t'(r_kh) * c_E_DIL_H;
    assign w_iw  = ext_t'(r_ow) * c_E_STRIDE_W - c_E_PAD_W + ext_t'(r_kw) * c_E_DIL_W;
    assign w_pad = (w_ih < 0) || (w_ih >= c_E_IN_H) || (w_iw < 0) || (w_iw >= c_E_IN_W);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Nested loop counters: advance one op per accepted transfer, held at zero outside RUN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oh <= '0;
            r_ow <= '0;
            r_ci <= '0;
            r_kh <= '0;
            r_kw <= '0;
        end else if (abort || (r_state != S_RUN)) begin
            r_oh <= '0;
            r_ow <= '0;
            r_ci <= '0;
            r_kh <= '0;
            r_kw <= '0;
        end else if (w_xfer) begin
            r_kw <= w_kw_end ? '0 : r_kw + 1'b1;
            if (w_kw_end) begin
                r_kh <= w_kh_end ? '0 : r_kh + 1'b1;
            end
            if (w_kw_end && w_kh_end) begin
                r_ci <= w_ci_end ? '0 : r_ci + 1'b1;
            end
            if (w_pix_end) begin
                r_ow <= w_ow_end ? '0 : r_ow + 1'b1;
            end
            if (w_pix_end && w_ow_end) begin
                r_oh <= w_oh_end ? '0 : r_oh + 1'b1;
            end
        end
    end

    // Next-state decode and all outputs; payload is forced to zero unless offered
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        op_valid     = 1'b0;
        op_in_addr   = '0;
        op_w_addr    = '0;
        op_out_addr  = '0;
        op_pad       = 1'b0;
        op_first     = 1'b0;
        op_last      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_RUN;
                end
            end
            S_RUN: begin
                busy     = 1'b1;
                op_valid = 1'b1;
                if (w_xfer && w_pass_end) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = !abort;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Cancel wins over everything, including a coincident start
        if (abort) begin
            w_next_state = S_IDLE;
        end

        if (op_valid) begin
            op_pad      = w_pad;
            op_in_addr  = w_pad ? '0 :
                          AW'(r_ci) * c_A_PLANE + w_ih[AW-1:0] * c_A_IN_W + w_iw[AW-1:0];
            op_w_addr   = AW'(r_ci) * c_A_KHKW + AW'(r_kh) * c_A_KW + AW'(r_kw);
            op_out_addr = AW'(r_oh) * c_A_OW + AW'(r_ow);
            op_first    = w_pix_first;
            op_last     = w_pix_end;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv2d_window_sequencer
// Purpose  : Scoreboard bench for conv2d_window_sequencer at default geometry
//            (8x12x3 input, 3x5 kernel, stride 1x2, pad 1x2, 8x6 output).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv2d_window_sequencer;

    typedef struct packed {
        logic [15:0] in_addr;
        logic [15:0] w_addr;
        logic [15:0] out_addr;
        logic        pad;
        logic        first;
        logic        last;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        busy;
    logic        done;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op_in_addr;
    logic [15:0] op_w_addr;
    logic [15:0] op_out_addr;
    logic        op_pad;
    logic        op_first;
    logic        op_last;

    int  n_vec = 0;
    int  n_err = 0;
    op_t exp_q[$];

    int  cyc = 0;
    int  xfer_cnt = 0;
    int  done_cnt = 0;
    int  last_cyc = 0;
    int  done_cyc = 0;
    bit  dir_en = 1'b0;
    bit  rnd_mode = 1'b0;
    bit  rdy_level = 1'b1;
    bit  stall_prev = 1'b0;
    op_t held;

    conv2d_window_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op_in_addr  (op_in_addr),
        .op_w_addr   (op_w_addr),
        .op_out_addr (op_out_addr),
        .op_pad      (op_pad),
        .op_first    (op_first),
        .op_last     (op_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference op for one loop point at default geometry
    function automatic op_t model_op(input int oh, input int ow, input int ci,
                                     input int kh, input int kw);
        op_t o;
        int  ih, iw;
        ih = oh - 1 + kh;
        iw = ow * 2 - 2 + kw;
        o.pad      = (ih < 0) || (ih >= 8) || (iw < 0) || (iw >= 12);
        o.in_addr  = o.pad ? 16'd0 : 16'(ci * 96 + ih * 12 + iw);
        o.w_addr   = 16'(ci * 15 + kh * 5 + kw);
        o.out_addr = 16'(oh * 6 + ow);
        o.first    = (ci == 0) && (kh == 0) && (kw == 0);
        o.last     = (ci == 2) && (kh == 2) && (kw == 4);
        return o;
    endfunction

    // Queue the first n ops of a pass in loop order oh, ow, ci, kh, kw
    task automatic push_ops(input int n);
        int k = 0;
        for (int oh = 0; oh < 8; oh++)
            for (int ow = 0; ow < 6; ow++)
                for (int ci = 0; ci < 3; ci++)
                    for (int kh = 0; kh < 3; kh++)
                        for (int kw = 0; kw < 5; kw++) begin
                            if (k < n) exp_q.push_back(model_op(oh, ow, ci, kh, kw));
                            k++;
                        end
    endtask

    // op_ready driver, changes just after each rising edge
    always @(posedge clk) begin
        #1;
        op_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_level;
    end

    // Monitor: stall stability, scoreboard pop on each transfer, done tracking
    always @(negedge clk) begin
        op_t act;
        op_t e;
        cyc++;
        act = '{op_in_addr, op_w_addr, op_out_addr, op_pad, op_first, op_last};
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (op_valid && stall_prev) begin
            n_vec++;
            if (act !== held) begin
                n_err++;
                $display("FAIL stall_hold: got %h expected %h", act, held);
            end
        end
        if (op_valid && op_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_op #%0d: got %h expected none", xfer_cnt, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    n_err++;
                    $display("FAIL op #%0d: got in=%0d w=%0d out=%0d pad=%b f=%b l=%b expected in=%0d w=%0d out=%0d pad=%b f=%b l=%b",
                             xfer_cnt, act.in_addr, act.w_addr, act.out_addr, act.pad, act.first, act.last,
                             e.in_addr, e.w_addr, e.out_addr, e.pad, e.first, e.last);
                end
            end
            if (dir_en && xfer_cnt == 0) begin
                chk("first_pad", op_pad, 1);
                chk("first_in", op_in_addr, 0);
                chk("first_w", op_w_addr, 0);
                chk("first_out", op_out_addr, 0);
                chk("first_first", op_first, 1);
                chk("first_last", op_last, 0);
            end
            if (dir_en && xfer_cnt == 923) begin
                chk("mid_pad", op_pad, 0);
                chk("mid_in", op_in_addr, 137);
                chk("mid_w", op_w_addr, 23);
                chk("mid_out", op_out_addr, 20);
            end
            if (dir_en && xfer_cnt == 2159) begin
                chk("final_w", op_w_addr, 44);
                chk("final_out", op_out_addr, 47);
                chk("final_pad", op_pad, 1);
                chk("final_last", op_last, 1);
            end
            xfer_cnt++;
            last_cyc = cyc;
        end
        stall_prev = op_valid && !op_ready;
        held       = act;
    end

    // Call just after a rising edge; the first op must appear one edge later
    task automatic start_pass();
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("start_valid", op_valid, 1);
        chk("start_busy", busy, 1);
    endtask

    // Returns at the rising edge after done was seen (block re-enters IDLE)
    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) begin
            n_err++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
        end
    endtask

    task automatic clear_counts();
        xfer_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic pass_checks(input string tag);
        chk({tag, "_xfers"}, xfer_cnt, 2160);
        chk({tag, "_done_count"}, done_cnt, 1);
        chk({tag, "_done_timing"}, done_cyc - last_cyc, 1);
        chk({tag, "_queue_left"}, exp_q.size(), 0);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", op_valid, 0);
        chk("rst_payload", {op_in_addr, op_w_addr, op_out_addr, op_pad, op_first, op_last} == '0, 1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Pass 1: always ready, with directed spot checks
        @(posedge clk);
        clear_counts();
        dir_en = 1'b1;
        push_ops(2160);
        start_pass();
        wait_done(3000);
        dir_en = 1'b0;
        pass_checks("pass1");
        @(negedge clk);
        chk("pass1_idle_busy", busy, 0);
        chk("pass1_idle_valid", op_valid, 0);

        // Pass 2: ~50% stalls, restart immediately from IDLE, stray start mid-pass
        @(posedge clk);
        clear_counts();
        rnd_mode = 1'b1;
        push_ops(2160);
        start_pass();
        repeat (300) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(12000);
        rnd_mode = 1'b0;
        pass_checks("pass2");

        // Abort after 100 transfers; the coincident 101st still counts
        @(posedge clk);
        clear_counts();
        push_ops(101);
        start_pass();
        n = 0;
        while (xfer_cnt < 100 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("abort_reached_100", xfer_cnt, 100);
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", op_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (5) @(posedge clk);
        chk("abort_no_done", done_cnt, 0);
        chk("abort_xfers", xfer_cnt, 101);
        chk("abort_queue_left", exp_q.size(), 0);

        // Restart after abort begins from the very first op
        @(posedge clk);
        clear_counts();
        push_ops(2160);
        start_pass();
        chk("restart_out", op_out_addr, 0);
        chk("restart_first", op_first, 1);
        wait_done(3000);
        pass_checks("pass3");

        // Simultaneous start and abort in IDLE stays in IDLE
        @(posedge clk);
        #1 start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_valid", op_valid, 0);

        // Reset between edges mid-pass clears outputs at once
        @(posedge clk);
        clear_counts();
        push_ops(2160);
        start_pass();
        repeat (50) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_valid", op_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_w_addr", op_w_addr, 0);
        chk("arst_out_addr", op_out_addr, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("arst_needs_start", busy, 0);
        chk("arst_no_op", op_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
